// File: rtl/rggen_axi4lite_master_if.sv
// AXI4-Lite bus bundle between the rggen AXI4-Lite master and a register-block slave.
// Widths are set at instantiation and must match the master's ADDRESS_WIDTH/BUS_WIDTH.
interface rggen_axi4lite_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/rggen_axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a request/response command port into
// AXI4-Lite read/write transactions. All AXI channel outputs come straight from flops.
// Optional feature macro: RGGEN_AXI4LITE_MASTER_RESPONSE_READY_EN adds i_response_ready
// so the response can be held until the local controller takes it.
module rggen_axi4lite_master #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_request_valid,
    output logic                     o_request_ready,
    input  logic                     i_request_write,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [BUS_WIDTH-1:0]     i_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_strobe,
    output logic                     o_response_valid,
`ifdef RGGEN_AXI4LITE_MASTER_RESPONSE_READY_EN
    input  logic                     i_response_ready,
`endif
    output logic [1:0]               o_response_status,
    output logic [BUS_WIDTH-1:0]     o_read_data,
    rggen_axi4lite_if.master         axi4lite_if
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESPONSE
    } state_e;

    state_e                   r_state;
    state_e                   w_next_state;

    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_bready;
    logic                     r_arvalid;
    logic                     r_rready;
    logic                     r_aw_done;
    logic                     r_w_done;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [BUS_WIDTH-1:0]     r_write_data;
    logic [BUS_WIDTH/8-1:0]   r_strobe;
    logic                     r_response_valid;
    logic [1:0]               r_response_status;
    logic [BUS_WIDTH-1:0]     r_read_data;

    logic                     w_request_accept;
    logic                     w_aw_handshake;
    logic                     w_w_handshake;
    logic                     w_b_accept;
    logic                     w_ar_handshake;
    logic                     w_r_handshake;
    logic                     w_response_ready;

`ifdef RGGEN_AXI4LITE_MASTER_RESPONSE_READY_EN
    assign w_response_ready = i_response_ready;
`else
    assign w_response_ready = 1'b1;
`endif

    // Ready is held low while reset is asserted, even though the state already reads IDLE.
    assign o_request_ready  = (r_state == IDLE) && i_rst_n;
    assign w_request_accept = i_request_valid && o_request_ready;
    assign w_aw_handshake   = r_awvalid && axi4lite_if.awready;
    assign w_w_handshake    = r_wvalid && axi4lite_if.wready;
    // A write response only counts once both address and data have been handed over.
    assign w_b_accept       = (r_state == WRITE) && r_bready && axi4lite_if.bvalid
                              && r_aw_done && r_w_done;
    assign w_ar_handshake   = r_arvalid && axi4lite_if.arready;
    assign w_r_handshake    = (r_state == READ) && r_rready && axi4lite_if.rvalid;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment first keeps this block combinational (no latch inferred).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_request_accept) w_next_state = i_request_write ? WRITE : READ;
            WRITE:    if (w_b_accept)       w_next_state = RESPONSE;
            READ:     if (w_r_handshake)    w_next_state = RESPONSE;
            RESPONSE: if (w_response_ready) w_next_state = IDLE;
            default:                        w_next_state = IDLE;
        endcase
    end

    // Registered AXI channel controls, request capture and response capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_awvalid         <= 1'b0;
            r_wvalid          <= 1'b0;
            r_bready          <= 1'b0;
            r_arvalid         <= 1'b0;
            r_rready          <= 1'b0;
            r_aw_done         <= 1'b0;
            r_w_done          <= 1'b0;
            r_address         <= '0;
            r_write_data      <= '0;
            r_strobe          <= '0;
            r_response_valid  <= 1'b0;
            r_response_status <= 2'b00;
            r_read_data       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_request_accept) begin
                        r_awvalid    <= i_request_write;
                        r_wvalid     <= i_request_write;
                        r_bready     <= i_request_write;
                        r_arvalid    <= !i_request_write;
                        r_rready     <= !i_request_write;
                        r_aw_done    <= 1'b0;
                        r_w_done     <= 1'b0;
                        r_address    <= i_address;
                        r_write_data <= i_write_data;
                        r_strobe     <= i_strobe;
                    end
                end
                WRITE: begin
                    // AW and W retire independently and never come back within this transaction.
                    if (w_aw_handshake) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_handshake) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_b_accept) begin
                        r_bready          <= 1'b0;
                        r_response_valid  <= 1'b1;
                        r_response_status <= axi4lite_if.bresp;
                        r_read_data       <= '0;
                    end
                end
                READ: begin
                    if (w_ar_handshake) begin
                        r_arvalid <= 1'b0;
                    end
                    if (w_r_handshake) begin
                        r_rready          <= 1'b0;
                        r_response_valid  <= 1'b1;
                        r_response_status <= axi4lite_if.rresp;
                        r_read_data       <= axi4lite_if.rdata;
                    end
                end
                RESPONSE: begin
                    if (w_response_ready) begin
                        r_response_valid <= 1'b0;
                    end
                end
                default: begin
                    r_response_valid <= 1'b0;
                end
            endcase
        end
    end

    assign axi4lite_if.awvalid = r_awvalid;
    assign axi4lite_if.awaddr  = r_address;
    assign axi4lite_if.awprot  = 3'b000;
    assign axi4lite_if.wvalid  = r_wvalid;
    assign axi4lite_if.wdata   = r_write_data;
    assign axi4lite_if.wstrb   = r_strobe;
    assign axi4lite_if.bready  = r_bready;
    assign axi4lite_if.arvalid = r_arvalid;
    assign axi4lite_if.araddr  = r_address;
    assign axi4lite_if.arprot  = 3'b000;
    assign axi4lite_if.rready  = r_rready;

    assign o_response_valid  = r_response_valid;
    assign o_response_status = r_response_status;
    assign o_read_data       = r_read_data;
endmodule

// File: tb/tb_rggen_axi4lite_master.sv
// Directed bench for rggen_axi4lite_master: the bench plays the AXI4-Lite slave cycle by
// cycle and compares DUT outputs against hand-computed values one time unit after each edge.
module tb_rggen_axi4lite_master;
    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            request_valid;
    logic            request_ready;
    logic            request_write;
    logic [AW-1:0]   address;
    logic [DW-1:0]   write_data;
    logic [DW/8-1:0] strobe;
    logic            response_valid;
    logic            response_ready;
    logic [1:0]      response_status;
    logic [DW-1:0]   read_data;

    int n_vectors;
    int n_miscompares;

    rggen_axi4lite_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) axi_bus ();

    rggen_axi4lite_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_request_valid   (request_valid),
        .o_request_ready   (request_ready),
        .i_request_write   (request_write),
        .i_address         (address),
        .i_write_data      (write_data),
        .i_strobe          (strobe),
        .o_response_valid  (response_valid),
`ifdef RGGEN_AXI4LITE_MASTER_RESPONSE_READY_EN
        .i_response_ready  (response_ready),
`endif
        .o_response_status (response_status),
        .o_read_data       (read_data),
        .axi4lite_if       (axi_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s);
        request_valid = 1'b1;
        request_write = wr;
        address       = a;
        write_data    = d;
        strobe        = s;
    endtask

    initial begin
        n_vectors      = 0;
        n_miscompares  = 0;
        rst_n          = 1'b0;
        request_valid  = 1'b0;
        request_write  = 1'b0;
        address        = '0;
        write_data     = '0;
        strobe         = '0;
        response_ready = 1'b1;
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bvalid  = 1'b0;
        axi_bus.bresp   = 2'b00;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.rresp   = 2'b00;

        // ---- reset state ----
        #12;
        check("rst_ready",   request_ready,   0);
        check("rst_awvalid", axi_bus.awvalid, 0);
        check("rst_wvalid",  axi_bus.wvalid,  0);
        check("rst_arvalid", axi_bus.arvalid, 0);
        check("rst_bready",  axi_bus.bready,  0);
        check("rst_rready",  axi_bus.rready,  0);
        check("rst_rspv",    response_valid,  0);
        check("rst_status",  response_status, 0);
        check("rst_rdata",   read_data,       0);
        check("rst_awaddr",  axi_bus.awaddr,  0);
        check("rst_araddr",  axi_bus.araddr,  0);
        check("rst_wdata",   axi_bus.wdata,   0);
        check("rst_wstrb",   axi_bus.wstrb,   0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_ready", request_ready, 1);

        // ---- write, slave always ready ----
        axi_bus.awready = 1'b1;
        axi_bus.wready  = 1'b1;
        request(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF);
        step();                                   // N+1
        request_valid = 1'b0;
        check("w1_awvalid", axi_bus.awvalid, 1);
        check("w1_wvalid",  axi_bus.wvalid,  1);
        check("w1_awaddr",  axi_bus.awaddr,  32'h0010);
        check("w1_wdata",   axi_bus.wdata,   32'hDEAD_BEEF);
        check("w1_wstrb",   axi_bus.wstrb,   4'hF);
        check("w1_bready",  axi_bus.bready,  1);
        check("w1_awprot",  axi_bus.awprot,  0);
        check("w1_ready",   request_ready,   0);
        step();                                   // N+2
        check("w1_awdrop", axi_bus.awvalid, 0);
        check("w1_wdrop",  axi_bus.wvalid,  0);
        check("w1_rspv_n2", response_valid, 0);
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = 2'b00;
        step();                                   // N+3
        axi_bus.bvalid = 1'b0;
        check("w1_rspv",   response_valid,  1);
        check("w1_status", response_status, 2'b00);
        check("w1_rdata",  read_data,       0);
        step();                                   // N+4
        check("w1_rspv_end", response_valid, 0);
        check("w1_ready_back", request_ready, 1);

        // ---- read with arready low for 5 cycles ----
        axi_bus.arready = 1'b0;
        request(1'b0, 16'h0024, 32'h0, 4'h0);
        step();                                   // N+1
        request_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("r1_arvalid_%0d", i), axi_bus.arvalid, 1);
            check($sformatf("r1_araddr_%0d", i),  axi_bus.araddr,  32'h0024);
            check($sformatf("r1_rready_%0d", i),  axi_bus.rready,  1);
            if (i == 5) axi_bus.arready = 1'b1;
            step();
        end
        axi_bus.arready = 1'b0;
        check("r1_ardrop", axi_bus.arvalid, 0);
        check("r1_arprot", axi_bus.arprot,  0);
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = 32'h1234_5678;
        axi_bus.rresp  = 2'b00;
        step();
        axi_bus.rvalid = 1'b0;
        check("r1_rspv",   response_valid,  1);
        check("r1_rdata",  read_data,       32'h1234_5678);
        check("r1_status", response_status, 2'b00);
        check("r1_rready_drop", axi_bus.rready, 0);
        step();
        check("r1_rspv_end", response_valid, 0);
        check("r1_ready_back", request_ready, 1);

        // ---- write, W accepted 3 cycles after AW, early B must wait, SLVERR ----
        axi_bus.awready = 1'b1;
        axi_bus.wready  = 1'b0;
        request(1'b1, 16'h0100, 32'hCAFE_F00D, 4'h3);
        step();                                   // N+1: AW handshake this cycle
        request_valid = 1'b0;
        check("w2_awvalid", axi_bus.awvalid, 1);
        check("w2_wvalid",  axi_bus.wvalid,  1);
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = 2'b10;
        for (int i = 0; i < 3; i++) begin         // N+2..N+4
            step();
            check($sformatf("w2_awlow_%0d", i),  axi_bus.awvalid, 0);
            check($sformatf("w2_whigh_%0d", i),  axi_bus.wvalid,  1);
            check($sformatf("w2_wdata_%0d", i),  axi_bus.wdata,   32'hCAFE_F00D);
            check($sformatf("w2_norsp_%0d", i),  response_valid,  0);
            if (i == 2) axi_bus.wready = 1'b1;
        end
        step();                                   // N+5: W done, B accepted this cycle
        axi_bus.wready = 1'b0;
        check("w2_wdrop",   axi_bus.wvalid,  0);
        check("w2_awstay",  axi_bus.awvalid, 0);
        check("w2_norsp_5", response_valid,  0);
        step();                                   // N+6
        axi_bus.bvalid = 1'b0;
        check("w2_rspv",   response_valid,  1);
        check("w2_status", response_status, 2'b10);
        check("w2_rdata",  read_data,       0);
        step();
        check("w2_ready_back", request_ready, 1);

        // ---- reset while waiting for rvalid ----
        axi_bus.arready = 1'b1;
        request(1'b0, 16'h0040, 32'h0, 4'h0);
        step();
        request_valid = 1'b0;
        check("rst2_arvalid", axi_bus.arvalid, 1);
        step();
        axi_bus.arready = 1'b0;
        check("rst2_ardrop", axi_bus.arvalid, 0);
        check("rst2_rready", axi_bus.rready,  1);
        step();
        rst_n = 1'b0;
        #1;
        check("rst2_arvalid_0", axi_bus.arvalid, 0);
        check("rst2_rready_0",  axi_bus.rready,  0);
        check("rst2_rspv_0",    response_valid,  0);
        check("rst2_ready_0",   request_ready,   0);
        @(negedge clk);
        rst_n = 1'b1;
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = 32'hFFFF_0000;
        step();
        check("rst2_ready_1", request_ready,  1);
        check("rst2_rspv_1",  response_valid, 0);
        check("rst2_rready_1", axi_bus.rready, 0);
        step();
        check("rst2_rspv_2",  response_valid, 0);
        axi_bus.rvalid = 1'b0;

        // ---- back-to-back writes, zero-wait slave ----
        axi_bus.awready = 1'b1;
        axi_bus.wready  = 1'b1;
        axi_bus.bvalid  = 1'b1;
        axi_bus.bresp   = 2'b01;
        request(1'b1, 16'h0200, 32'h0BAD_CAFE, 4'h1);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("b2b_ready_%0d", k), request_ready,  (k % 4) == 0);
            check($sformatf("b2b_rspv_%0d", k),  response_valid, (k % 4) == 3);
            step();
        end
        request_valid = 1'b0;
        step();
        step();                                   // response of third request
        check("b2b_rspv_last",   response_valid,  1);
        check("b2b_status_last", response_status, 2'b01);
        step();
        check("b2b_ready_end", request_ready, 1);
        axi_bus.bvalid  = 1'b0;
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;

`ifdef RGGEN_AXI4LITE_MASTER_RESPONSE_READY_EN
        // ---- response held while i_response_ready is low ----
        axi_bus.arready = 1'b1;
        request(1'b0, 16'h0080, 32'h0, 4'h0);
        step();                                   // N+1
        request_valid = 1'b0;
        step();                                   // N+2
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b1;
        axi_bus.rdata   = 32'hA5A5_0F0F;
        axi_bus.rresp   = 2'b11;
        response_ready  = 1'b0;
        step();                                   // N+3
        axi_bus.rvalid = 1'b0;
        axi_bus.rdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold_rspv_%0d", i),   response_valid,  1);
            check($sformatf("hold_rdata_%0d", i),  read_data,       32'hA5A5_0F0F);
            check($sformatf("hold_status_%0d", i), response_status, 2'b11);
            check($sformatf("hold_ready_%0d", i),  request_ready,   0);
            step();
        end
        response_ready = 1'b1;
        check("hold_rspv_rel", response_valid, 1);
        step();
        check("hold_rspv_end", response_valid, 0);
        check("hold_ready_back", request_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
